fnd_scan_capture: RTL and testbench

//  Receive-side counterpart of the multiplexed 4-digit FND driver. Samples the an/seg/dp scan lines,

---
 rtl/fnd_pkg.sv | 45 ++++
 rtl/fnd_scan_capture_decode.sv | 33 +++
 rtl/fnd_scan_capture.sv | 139 +++++++++++++
 tb/tb_fnd_scan_capture.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Segment/anode encodings shared by the FND scan driver and the scan capture block.
// Segment vectors are {a,b,c,d,e,f,g}, active-low.
package fnd_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_F = 4'hA;
    localparam logic [3:0] CODE_B = 4'hB;
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    function automatic logic an_is_lit(input logic [3:0] an);
        return $onehot(~an);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/fnd_scan_capture_decode.sv
// Combinational segment-pattern decoder: maps an active-low 7-segment pattern back to its code.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       recognised
);

    always_comb begin
        code       = 4'h0;
        recognised = 1'b1;
        case (seg)
            SEG_0:   code = 4'd0;
            SEG_1:   code = 4'd1;
            SEG_2:   code = 4'd2;
            SEG_3:   code = 4'd3;
            SEG_4:   code = 4'd4;
            SEG_5:   code = 4'd5;
            SEG_6:   code = 4'd6;
            SEG_7:   code = 4'd7;
            SEG_8:   code = 4'd8;
            SEG_9:   code = 4'd9;
            SEG_F:   code = CODE_F;
            SEG_B:   code = CODE_B;
            default: begin
                code       = 4'h0;
                recognised = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fnd_scan_capture.sv
// Scan-line capture for a multiplexed 4-digit FND: debounces each scan slot, decodes it,
// and rebuilds the displayed digits and per-frame flags.
module fnd_scan_capture
    import fnd_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024,
    parameter int TIMEOUT       = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_err,
    output logic [3:0]  dp_on,
    output logic [3:0]  active_mask,
    output logic        frame_done,
    output logic        overlap_err,
    output logic        stale
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_PRE  = SW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [SW-1:0] stab_cnt;
    logic          accept;
    logic          same;

    scan_state_t   state;
    logic [TW-1:0] to_cnt;
    logic [3:0]    seen;

    logic [3:0]    code;
    logic          recognised;
    logic          lit;
    logic [1:0]    idx;
    logic          frame_close;
    logic [3:0]    valid_base;
    logic [3:0]    err_base;

    assign same = ({an, seg, dp} == {an_q, seg_q, dp_q});

    // accept is registered so it is high exactly in the cycle stab_cnt first sits at STAB_LAST
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q     <= AN_OFF;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            stab_cnt <= '0;
            accept   <= 1'b0;
        end else begin
            an_q   <= an;
            seg_q  <= seg;
            dp_q   <= dp;
            accept <= same && (stab_cnt == STAB_PRE);
            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_LAST)
                stab_cnt <= stab_cnt + SW'(1);
        end
    end

    fnd_seg_decode u_decode (
        .seg        (seg_q),
        .code       (code),
        .recognised (recognised)
    );

    always_comb begin
        lit         = an_is_lit(an_q);
        idx         = an_index(an_q);
        frame_close = accept && lit && seen[idx];
        valid_base  = frame_close ? (digit_valid & seen) : digit_valid;
        err_base    = frame_close ? (digit_err & seen) : digit_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            seen        <= 4'h0;
            digits      <= 16'h0;
            digit_valid <= 4'h0;
            digit_err   <= 4'h0;
            dp_on       <= 4'h0;
            active_mask <= 4'h0;
            frame_done  <= 1'b0;
            overlap_err <= 1'b0;
            stale       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                to_cnt <= '0;
                if (state == ST_IDLE) begin
                    state <= ST_SCAN;
                    stale <= 1'b0;
                end
                if (lit) begin
                    digit_valid      <= valid_base;
                    digit_err        <= err_base;
                    digit_valid[idx] <= recognised;
                    digit_err[idx]   <= !recognised;
                    digits[4*idx +: 4] <= code;
                    dp_on[idx]       <= !dp_q;
                    if (frame_close) begin
                        frame_done  <= 1'b1;
                        active_mask <= seen;
                        seen        <= 4'b0001 << idx;
                    end else begin
                        seen[idx] <= 1'b1;
                    end
                end else if (an_q != AN_OFF) begin
                    overlap_err <= 1'b1;
                end
            end else if (state == ST_SCAN) begin
                if (to_cnt == TO_LAST) begin
                    state       <= ST_IDLE;
                    stale       <= 1'b1;
                    to_cnt      <= '0;
                    digit_valid <= 4'h0;
                    digit_err   <= 4'h0;
                    active_mask <= 4'h0;
                    seen        <= 4'h0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_capture.sv
// Directed bench for fnd_scan_capture with STABLE_CYCLES=4, TIMEOUT=64.
module tb_fnd_scan_capture;
    import fnd_pkg::*;

    localparam int STABLE = 4;
    localparam int TMO    = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  digit_valid, digit_err, dp_on, active_mask;
    logic        frame_done, overlap_err, stale;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        int          cycles;
        bit          chk;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  err;
        logic [3:0]  mask;
        logic [3:0]  dpo;
        int          frames;
    } vec_t;

    vec_t vecs[12];

    fnd_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digits      (digits),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .dp_on       (dp_on),
        .active_mask (active_mask),
        .frame_done  (frame_done),
        .overlap_err (overlap_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    // Counted shortly after the edge so a 2-cycle pulse shows up as two frames.
    always @(posedge clk) begin
        #2;
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an  = a;
        seg = s;
        dp  = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " digits"}, 32'(digits), 0);
        check({tag, " valid"}, 32'(digit_valid), 0);
        check({tag, " err"}, 32'(digit_err), 0);
        check({tag, " dp_on"}, 32'(dp_on), 0);
        check({tag, " mask"}, 32'(active_mask), 0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
        check({tag, " overlap"}, 32'(overlap_err), 0);
        check({tag, " stale"}, 32'(stale), 0);
    endtask

    initial begin
        // normal 4-digit scan, dp lit on digit 0
        vecs[0]  = '{4'b0111, SEG_F, 1'b1, 20, 1'b0, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 0};
        vecs[1]  = '{4'b1011, SEG_1, 1'b1, 20, 1'b0, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 0};
        vecs[2]  = '{4'b1101, SEG_2, 1'b1, 20, 1'b0, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 0};
        vecs[3]  = '{4'b1110, SEG_5, 1'b0, 20, 1'b1, 16'hA125, 4'hF, 4'h0, 4'h0, 4'h1, 0};
        vecs[4]  = '{4'b0111, SEG_F, 1'b1, 20, 1'b1, 16'hA125, 4'hF, 4'h0, 4'hF, 4'h1, 1};
        // timer pattern with long blank slots
        vecs[5]  = '{4'b1110, SEG_7, 1'b1, 20, 1'b0, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 0};
        vecs[6]  = '{4'b1101, SEG_4, 1'b1, 20, 1'b0, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 0};
        vecs[7]  = '{AN_OFF, SEG_BLANK, 1'b1, 40, 1'b1, 16'hA147, 4'hF, 4'h0, 4'hF, 4'h0, 1};
        vecs[8]  = '{4'b1110, SEG_7, 1'b1, 20, 1'b1, 16'hA147, 4'hB, 4'h0, 4'hB, 4'h0, 2};
        vecs[9]  = '{4'b1101, SEG_4, 1'b1, 20, 1'b0, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 0};
        vecs[10] = '{AN_OFF, SEG_BLANK, 1'b1, 40, 1'b0, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 0};
        vecs[11] = '{4'b1110, SEG_7, 1'b1, 20, 1'b1, 16'hA147, 4'h3, 4'h0, 4'h3, 4'h0, 3};

        reset = 1'b1;
        an    = AN_OFF;
        seg   = SEG_BLANK;
        dp    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");

        for (int i = 0; i < 12; i++) begin
            hold(vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].cycles);
            if (vecs[i].chk) begin
                check($sformatf("v%0d digits", i), 32'(digits), 32'(vecs[i].digits));
                check($sformatf("v%0d valid", i), 32'(digit_valid), 32'(vecs[i].valid));
                check($sformatf("v%0d err", i), 32'(digit_err), 32'(vecs[i].err));
                check($sformatf("v%0d mask", i), 32'(active_mask), 32'(vecs[i].mask));
                check($sformatf("v%0d dp_on", i), 32'(dp_on), 32'(vecs[i].dpo));
                check($sformatf("v%0d frames", i), 32'(fd_cnt), 32'(vecs[i].frames));
            end
        end

        // glitching slot: never stable long enough to accept
        for (int k = 0; k < 8; k++)
            hold(4'b1101, (k % 2 == 0) ? SEG_3 : SEG_8, 1'b1, 3);
        check("glitch digits", 32'(digits), 32'h0000_A147);
        check("glitch valid", 32'(digit_valid), 32'h3);
        check("glitch frames", 32'(fd_cnt), 3);
        hold(4'b1101, SEG_3, 1'b1, 5);
        check("settled digits", 32'(digits), 32'h0000_A137);

        // unrecognised pattern closes the frame and flags digit 0
        hold(4'b1110, 7'b1111110, 1'b1, 10);
        check("bad digits", 32'(digits), 32'h0000_A130);
        check("bad valid", 32'(digit_valid), 32'h2);
        check("bad err", 32'(digit_err), 32'h1);
        check("bad mask", 32'(active_mask), 32'h3);
        check("bad frames", 32'(fd_cnt), 4);
        hold(4'b1100, SEG_8, 1'b1, 5);
        check("overlap set", 32'(overlap_err), 1);
        check("overlap digits", 32'(digits), 32'h0000_A130);
        hold(4'b1011, SEG_1, 1'b1, 10);
        check("overlap sticky", 32'(overlap_err), 1);

        // timeout with frozen inputs
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset2");
        hold(4'b0111, SEG_F, 1'b1, 20);
        hold(4'b1011, SEG_1, 1'b1, 20);
        hold(4'b1101, SEG_2, 1'b1, 20);
        hold(4'b1110, SEG_5, 1'b1, 20);
        hold(4'b0111, SEG_F, 1'b1, 5);
        check("pre-to frames", 32'(fd_cnt), 5);
        check("pre-to mask", 32'(active_mask), 32'hF);
        hold(4'b0111, SEG_F, 1'b1, TMO - 1);
        check("to-1 stale", 32'(stale), 0);
        check("to-1 valid", 32'(digit_valid), 32'hF);
        hold(4'b0111, SEG_F, 1'b1, 1);
        check("to stale", 32'(stale), 1);
        check("to valid", 32'(digit_valid), 0);
        check("to mask", 32'(active_mask), 0);
        check("to digits", 32'(digits), 32'h0000_A125);
        check("to frames", 32'(fd_cnt), 5);
        hold(4'b1011, SEG_1, 1'b1, 5);
        check("post-to stale", 32'(stale), 0);
        check("post-to valid", 32'(digit_valid), 32'h4);
        check("post-to frames", 32'(fd_cnt), 5);

        // reset mid-slot, then exact first-accept latency
        hold(4'b1110, SEG_5, 1'b1, 2);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (STABLE) @(negedge clk);
        check("early digits", 32'(digits), 0);
        check("early valid", 32'(digit_valid), 0);
        @(negedge clk);
        check("first digits", 32'(digits), 32'h0000_0005);
        check("first valid", 32'(digit_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
